// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port indices and helpers for mem_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

   localparam logic [1:0] PORT_LOADER = 2'd0;
   localparam logic [1:0] PORT_FETCH  = 2'd1;
   localparam logic [1:0] PORT_DATA   = 2'd2;
   localparam logic [1:0] NO_GRANT    = 2'd3;

   // Loader first; fetch/data tie goes to whichever was not served last.
   function automatic logic [1:0] arb_pick(input logic [2:0] req, input logic [1:0] rr_last);
      return req[0]           ? PORT_LOADER :
             (req[1] & req[2]) ? ((rr_last == PORT_FETCH) ? PORT_DATA : PORT_FETCH) :
             req[1]           ? PORT_FETCH :
             req[2]           ? PORT_DATA : NO_GRANT;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return v + {15'd0, (v != 16'hFFFF)};
   endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: 2**ADDR_W x DATA_W storage, synchronous write, registered read, no reset.
module mem_array #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i)
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else      rdata_o       <= mem_q[addr_i];
      end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port (loader/fetch/data) arbiter for the unified memory, IDLE->ACCESS->RESP.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic [2:0]          req_i,
   input  logic [2:0]          we_i,
   input  logic [3*ADDR_W-1:0] addr_i,
   input  logic [3*DATA_W-1:0] wdata_i,
   output logic [2:0]          ack_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                busy_o,
   output logic [1:0]          grant_id_o
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]         grant_cnt0_o,
   output logic [15:0]         grant_cnt1_o,
   output logic [15:0]         grant_cnt2_o,
   output logic [15:0]         conflict_cnt_o
`endif
);

   arb_state_t        state_q, state_d;
   logic [1:0]        grant_q, grant_d, rr_q, rr_d, win;
   logic              we_q, rd_seen_q, take;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, mem_rdata;

   always_comb begin
      win     = arb_pick(req_i, rr_q);
      take    = (state_q == IDLE) && (|req_i);
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      unique case (state_q)
         IDLE: if (take) begin
            state_d = ACCESS;
            grant_d = win;
            rr_d    = (win == PORT_LOADER) ? rr_q : win;
         end
         ACCESS: state_d = RESP;
         RESP: begin
            state_d = IDLE;
            grant_d = NO_GRANT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         state_q   <= IDLE;
         grant_q   <= NO_GRANT;
         rr_q      <= PORT_DATA;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_seen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         if (take) begin
            we_q    <= we_i[win];
            addr_q  <= addr_i[win*ADDR_W +: ADDR_W];
            wdata_q <= wdata_i[win*DATA_W +: DATA_W];
         end
         if (state_q == ACCESS && !we_q) rd_seen_q <= 1'b1;
      end

   // Enable derives from the async-reset state, so reset during ACCESS cancels the write.
   mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk_i   (clk_i),
      .en_i    (state_q == ACCESS),
      .we_i    (we_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // The array read register is not reset; mask it until the first read lands.
   assign rdata_o    = rd_seen_q ? mem_rdata : '0;
   assign ack_o      = (state_q == RESP) ? 3'(3'b001 << grant_q) : 3'b000;
   assign busy_o     = state_q != IDLE;
   assign grant_id_o = grant_q;

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         grant_cnt0_o   <= '0;
         grant_cnt1_o   <= '0;
         grant_cnt2_o   <= '0;
         conflict_cnt_o <= '0;
      end else if (take) begin
         if (win == PORT_LOADER) grant_cnt0_o <= sat_inc(grant_cnt0_o);
         if (win == PORT_FETCH)  grant_cnt1_o <= sat_inc(grant_cnt1_o);
         if (win == PORT_DATA)   grant_cnt2_o <= sat_inc(grant_cnt2_o);
         if ((req_i & (req_i - 3'd1)) != 3'd0) conflict_cnt_o <= sat_inc(conflict_cnt_o);
      end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a grant/memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  req, we;
   logic [11:0] addr;
   logic [23:0] wdata;
   logic [2:0]  ack;
   logic [7:0]  rdata;
   logic        busy;
   logic [1:0]  grant_id;
`ifdef MEM_ARB_PERF_EN
   logic [15:0] gc0, gc1, gc2, cc;
`endif

   mem_arbiter dut (
      .clk_i      (clk),
      .reset_ni   (reset_n),
      .req_i      (req),
      .we_i       (we),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .ack_o      (ack),
      .rdata_o    (rdata),
      .busy_o     (busy),
      .grant_id_o (grant_id)
`ifdef MEM_ARB_PERF_EN
      ,
      .grant_cnt0_o   (gc0),
      .grant_cnt1_o   (gc1),
      .grant_cnt2_o   (gc2),
      .conflict_cnt_o (cc)
`endif
   );

   always #5 clk = ~clk;

   int         n_chk = 0, n_err = 0;
   logic [7:0] mem_m [16];
   logic [7:0] last_rd;
   int         rr;
   logic       pw [3];
   logic [3:0] pa [3];
   logic [7:0] pd [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic w, input logic [3:0] a, input logic [7:0] d);
      we[p] = w;
      addr[p*4 +: 4] = a;
      wdata[p*8 +: 8] = d;
      pw[p] = w;
      pa[p] = a;
      pd[p] = d;
   endtask

   function automatic int model_pick(input logic [2:0] m);
      if (m[0]) return 0;
      if (m[1] && m[2]) return (rr == 1) ? 2 : 1;
      return m[1] ? 1 : 2;
   endfunction

   // Present `mask` requests; after the first completion also raise `late`.
   task automatic serve(input logic [2:0] mask, input logic [2:0] late);
      logic [2:0] pend;
      int n, w;
      bit first;
      pend = mask;
      req = mask;
      first = 1;
      while (pend != 3'b000) begin
         w = model_pick(pend);
         if (w != 0) rr = w;
         n = 0;
         do begin
            tick;
            n++;
         end while (ack == 3'b000 && n < 8);
         chk("latency", n, 2);
         if (ack == 3'b000) begin
            req = 3'b000;
            return;
         end
         chk("ack_onehot", ack, 1 << w);
         chk("grant_id", grant_id, w);
         chk("busy_active", busy, 1);
         if (pw[w]) mem_m[pa[w]] = pd[w];
         else last_rd = mem_m[pa[w]];
         chk("rdata", rdata, last_rd);
         tick;
         chk("ack_pulse", ack, 0);
         pend[w] = 1'b0;
         if (first) pend |= late;
         first = 0;
         req = pend;
      end
      chk("idle_busy", busy, 0);
      chk("idle_grant", grant_id, 3);
   endtask

   localparam logic [7:0] PROG [5] = '{8'h13, 8'h94, 8'h20, 8'h6A, 8'h74};

   initial begin
      req = '0; we = '0; addr = '0; wdata = '0;
      reset_n = 1'b0;
      rr = 2;
      last_rd = 8'h00;
      tick;
      tick;
      chk("rst_ack", ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 3);
      reset_n = 1'b1;
      tick;
      chk("idle_after_rst", busy, 0);

      // all three request together: order 0, 1, 2
      set_port(0, 1, 4'd13, 8'hA1);
      set_port(1, 1, 4'd14, 8'hB2);
      set_port(2, 1, 4'd15, 8'hC3);
      serve(3'b111, 3'b000);
`ifdef MEM_ARB_PERF_EN
      chk("grant_cnt0", gc0, 1);
      chk("grant_cnt1", gc1, 1);
      chk("grant_cnt2", gc2, 1);
      chk("conflict_cnt", cc, 2);
`endif

      // loader write then fetch read-back
      set_port(0, 1, 4'd3, 8'd5);
      serve(3'b001, 3'b000);
      set_port(1, 0, 4'd3, 8'd0);
      serve(3'b010, 3'b000);
      chk("loader_rd", rdata, 5);

      // preload the whole memory, program image at 0..4
      for (int a = 0; a < 16; a++) begin
         set_port(0, 1, 4'(a), (a < 5) ? PROG[a] : 8'($urandom_range(0, 255)));
         serve(3'b001, 3'b000);
      end

      // data write then fetch read of the same word
      set_port(2, 1, 4'd10, 8'd12);
      serve(3'b100, 3'b000);
      set_port(1, 0, 4'd10, 8'd0);
      serve(3'b010, 3'b000);
      chk("raw_rd", rdata, 12);

      // round-robin with re-raise, then loader arriving mid-stream
      set_port(1, 0, 4'd1, 8'd0);
      set_port(2, 0, 4'd2, 8'd0);
      serve(3'b110, 3'b110);
      serve(3'b110, 3'b110);
      set_port(0, 1, 4'd9, 8'h5A);
      serve(3'b110, 3'b001);

      for (int i = 0; i < 60; i++) begin
         for (int p = 0; p < 3; p++)
            set_port(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         serve(3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)));
      end

      // reset during ACCESS aborts the write
      set_port(2, 1, 4'd5, 8'h11);
      serve(3'b100, 3'b000);
      set_port(2, 1, 4'd5, 8'hAA);
      req = 3'b100;
      tick;
      chk("access_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_ack", ack, 0);
      chk("abort_grant", grant_id, 3);
      chk("abort_busy", busy, 0);
      req = 3'b000;
      tick;
      reset_n = 1'b1;
      rr = 2;
      last_rd = 8'h00;
      chk("abort_rdata", rdata, 0);
      set_port(1, 0, 4'd5, 8'd0);
      serve(3'b010, 3'b000);
      chk("abort_mem", rdata, 8'h11);

      // reset during RESP drops ack at once; the write already landed
      set_port(0, 1, 4'd7, 8'h3C);
      req = 3'b001;
      tick;
      tick;
      chk("resp_ack", ack, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("resp_rst_ack", ack, 0);
      mem_m[7] = 8'h3C;
      req = 3'b000;
      tick;
      reset_n = 1'b1;
      rr = 2;
      last_rd = 8'h00;
      tick;
      chk("no_reissue", ack, 0);
      set_port(2, 0, 4'd7, 8'd0);
      serve(3'b100, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
